// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: hands the 68000 system bus to the UART loader/DMA
// engine through the BR/BG/BGACK handshake, bounds the loader's tenure and
// then gives the CPU a guaranteed cooldown slot before the next request.
// Optional build macro: ARB_GRANT_TIMEOUT_EN (abandon a request that is not
// granted within GRANT_TIMEOUT cycles).
//
// Handshake: BR rises when the loader requests and stays up until the bus
// is taken. BG_IN from the CPU moves us to waiting for the bus to go idle.
// The first sampled AS_IN=0 then drops BR, raises BGACK and DMA_GNT
// together. BGACK is held one extra cycle after DMA_GNT falls so the loader
// drivers are off the bus before the CPU takes it back.
module bus_master_arbiter #(
  parameter int MAX_HOLD      = 64,
  parameter int CPU_SLOT      = 16,
  parameter int GRANT_TIMEOUT = 1024
) (
  input  logic       MCLK_IN,
  input  logic       RESET_IN,
  input  logic       RUN_IN,
  input  logic       DMA_REQ_IN,
  input  logic       DMA_DONE_IN,
  input  logic       BG_IN,
  input  logic       AS_IN,
  output logic       BR,
  output logic       BGACK,
  output logic       DMA_GNT,
  output logic       DMA_YIELD,
  output logic [7:0] GRANT_COUNT,
  output logic       ARB_TIMEOUT,
  output logic [2:0] DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQUEST   = 3'd1,
    S_WAIT_FREE = 3'd2,
    S_OWNED     = 3'd3,
    S_YIELD     = 3'd4,
    S_RELEASE   = 3'd5
  } state_t;

  // Hold counter only needs to reach MAX_HOLD-1.
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  // Cooldown counter is loaded with CPU_SLOT and counts down to 0.
  localparam int CW = (CPU_SLOT > 0) ? $clog2(CPU_SLOT + 1) : 1;
  localparam logic [CW-1:0] COOL_LOAD = CW'(CPU_SLOT);

  state_t          r_state;
  logic            r_br;
  logic            r_bgack;
  logic            r_gnt;
  logic            r_yield;
  logic [7:0]      r_count;
  logic            r_timeout;
  logic [HW-1:0]   r_hold;
  logic [CW-1:0]   r_cool;

  logic            w_hold_hit;
  logic            w_req_ok;
  logic            w_to_fire;

  // MAX_HOLD of 0 means the loader may keep the bus indefinitely.
  assign w_hold_hit = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);

`ifdef ARB_GRANT_TIMEOUT_EN
  localparam int TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = (GRANT_TIMEOUT > 0) ? TW'(GRANT_TIMEOUT - 1) : '0;

  logic [TW-1:0] r_to_cnt;
  logic          r_req_block;
  logic          w_to_hit;

  assign w_to_hit = (r_to_cnt == TO_LAST);
  // Timeout fires only where the FSM would otherwise keep waiting.
  assign w_to_fire = w_to_hit &&
                     (((r_state == S_REQUEST) && DMA_REQ_IN && !BG_IN) ||
                      ((r_state == S_WAIT_FREE) && AS_IN));
  // After a timeout the request must be withdrawn before it counts again.
  assign w_req_ok = DMA_REQ_IN && !r_req_block;

  // Wait-for-grant counter and the request re-arm flag.
  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN || !RUN_IN) begin
      r_to_cnt    <= '0;
      r_req_block <= 1'b0;
    end else begin
      if ((r_state == S_REQUEST) || (r_state == S_WAIT_FREE)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
      if (!DMA_REQ_IN) begin
        r_req_block <= 1'b0;
      end
      if (w_to_fire) begin
        r_req_block <= 1'b1;
      end
    end
  end
`else
  // No timeout in this build; the parameter is referenced so both builds
  // share one interface.
  assign w_to_fire = 1'b0 && (GRANT_TIMEOUT != 0);
  assign w_req_ok  = DMA_REQ_IN;
`endif

  // Arbitration FSM with all bus-side outputs registered.
  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN || !RUN_IN) begin
      r_state   <= S_IDLE;
      r_br      <= 1'b0;
      r_bgack   <= 1'b0;
      r_gnt     <= 1'b0;
      r_yield   <= 1'b0;
      r_timeout <= 1'b0;
      r_hold    <= '0;
      r_cool    <= '0;
      // Stopping the CPU keeps the grant history; only reset clears it.
      if (RESET_IN) begin
        r_count <= 8'd0;
      end
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_cool != '0) begin
            r_cool <= r_cool - 1'b1;
          end else if (w_req_ok) begin
            r_state <= S_REQUEST;
            r_br    <= 1'b1;
          end
        end
        S_REQUEST: begin
          if (!DMA_REQ_IN) begin
            r_state <= S_IDLE;
            r_br    <= 1'b0;
          end else if (BG_IN) begin
            r_state <= S_WAIT_FREE;
          end else if (w_to_fire) begin
            r_state   <= S_IDLE;
            r_br      <= 1'b0;
            r_cool    <= COOL_LOAD;
            r_timeout <= 1'b1;
          end
        end
        S_WAIT_FREE: begin
          if (!AS_IN) begin
            r_state <= S_OWNED;
            r_br    <= 1'b0;
            r_bgack <= 1'b1;
            r_gnt   <= 1'b1;
            r_hold  <= '0;
            r_count <= r_count + 8'd1;
          end else if (w_to_fire) begin
            r_state   <= S_IDLE;
            r_br      <= 1'b0;
            r_cool    <= COOL_LOAD;
            r_timeout <= 1'b1;
          end
        end
        S_OWNED: begin
          if (DMA_DONE_IN) begin
            r_state <= S_RELEASE;
            r_gnt   <= 1'b0;
          end else begin
            r_hold <= r_hold + 1'b1;
            if (w_hold_hit) begin
              r_state <= S_YIELD;
              r_yield <= 1'b1;
            end
          end
        end
        S_YIELD: begin
          // Loader keeps the bus until it finishes its current transfer.
          if (DMA_DONE_IN) begin
            r_state <= S_RELEASE;
            r_gnt   <= 1'b0;
            r_yield <= 1'b0;
          end
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
          r_bgack <= 1'b0;
          r_cool  <= COOL_LOAD;
        end
        default: begin
          r_state <= S_IDLE;
          r_br    <= 1'b0;
          r_bgack <= 1'b0;
          r_gnt   <= 1'b0;
          r_yield <= 1'b0;
        end
      endcase
    end
  end

  assign BR          = r_br;
  assign BGACK       = r_bgack;
  assign DMA_GNT     = r_gnt;
  assign DMA_YIELD   = r_yield;
  assign GRANT_COUNT = r_count;
  assign ARB_TIMEOUT = r_timeout;
  assign DBG_STATE   = r_state;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Bench for bus_master_arbiter: directed phases followed by random traffic,
// every cycle compared against a behavioural model of the bus ownership.
module tb_bus_master_arbiter;

  localparam int MAX_HOLD      = 4;
  localparam int CPU_SLOT      = 5;
  localparam int GRANT_TIMEOUT = 8;
`ifdef ARB_GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, run, req, done, bg, bus_busy;
  logic       br, bgack, gnt, yld, tmo;
  logic [7:0] gcount;
  logic [2:0] dbg_state;

  bus_master_arbiter #(
    .MAX_HOLD(MAX_HOLD), .CPU_SLOT(CPU_SLOT), .GRANT_TIMEOUT(GRANT_TIMEOUT)
  ) dut (
    .MCLK_IN(clk), .RESET_IN(rst), .RUN_IN(run), .DMA_REQ_IN(req),
    .DMA_DONE_IN(done), .BG_IN(bg), .AS_IN(bus_busy), .BR(br),
    .BGACK(bgack), .DMA_GNT(gnt), .DMA_YIELD(yld), .GRANT_COUNT(gcount),
    .ARB_TIMEOUT(tmo), .DBG_STATE(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model: who holds the bus and what the loader is waiting for.
  bit m_asking;     // BR raised, waiting for the CPU to grant
  bit m_granted;    // CPU granted, waiting for the bus to go idle
  bit m_loader;     // loader drives the bus
  bit m_told_yield; // loader has been told to wrap up
  bit m_turn;       // one-cycle turnaround after the loader lets go
  bit m_blocked;    // request must be withdrawn before it counts again
  bit m_to_pulse;
  int m_tenure;     // cycles the loader has held the bus
  int m_waited;     // cycles spent asking for the bus
  int m_cool;       // CPU cycles still owed
  int m_grants;

  // Scoreboard of expected output vectors for the current cycle
  logic [7:0] exp_q[$];

  task automatic model_clear();
    m_asking = 0; m_granted = 0; m_loader = 0; m_told_yield = 0;
    m_turn = 0; m_blocked = 0; m_to_pulse = 0;
    m_tenure = 0; m_waited = 0; m_cool = 0;
  endtask

  task automatic give_up();
    m_asking = 0; m_granted = 0; m_cool = CPU_SLOT; m_to_pulse = 1;
  endtask

  task automatic model_step();
    bit blk_old;
    if (rst) begin model_clear(); m_grants = 0; return; end
    if (!run) begin model_clear(); return; end
    blk_old = m_blocked;
    m_to_pulse = 0;
    if (m_turn) begin
      m_turn = 0;
      m_cool = CPU_SLOT;
    end else if (m_loader) begin
      if (done) begin
        m_loader = 0; m_told_yield = 0; m_turn = 1;
      end else begin
        m_tenure++;
        if (MAX_HOLD > 0 && m_tenure == MAX_HOLD) m_told_yield = 1;
      end
    end else if (m_granted) begin
      m_waited++;
      if (!bus_busy) begin
        m_granted = 0; m_loader = 1; m_tenure = 0; m_grants++;
      end else if (TO_EN && m_waited >= GRANT_TIMEOUT) begin
        give_up();
      end
    end else if (m_asking) begin
      m_waited++;
      if (!req) m_asking = 0;
      else if (bg) begin m_asking = 0; m_granted = 1; end
      else if (TO_EN && m_waited >= GRANT_TIMEOUT) give_up();
    end else begin
      if (m_cool > 0) m_cool--;
      else if (req && !blk_old) begin m_asking = 1; m_waited = 0; end
    end
    if (!req) m_blocked = 0;
    if (m_to_pulse) m_blocked = 1;
  endtask

  task automatic check1(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    exp_q.delete();
    exp_q.push_back({7'd0, m_asking | m_granted});
    exp_q.push_back({7'd0, m_loader | m_turn});
    exp_q.push_back({7'd0, m_loader});
    exp_q.push_back({7'd0, m_told_yield});
    exp_q.push_back(8'(m_grants % 256));
    exp_q.push_back({7'd0, m_to_pulse});
    check1("br",          {7'd0, br},    exp_q.pop_front());
    check1("bgack",       {7'd0, bgack}, exp_q.pop_front());
    check1("dma_gnt",     {7'd0, gnt},   exp_q.pop_front());
    check1("dma_yield",   {7'd0, yld},   exp_q.pop_front());
    check1("grant_count", gcount,        exp_q.pop_front());
    check1("arb_timeout", {7'd0, tmo},   exp_q.pop_front());
  endtask

  // Driver: advance one clock, update the model, compare everything.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_grant(input string tag);
    for (int i = 0; i < 60 && !m_loader; i++) tick();
    check1(tag, {7'd0, gnt}, 8'd1);
  endtask

  task automatic pulse_done();
    done = 1'b1; tick(); done = 1'b0;
  endtask

  initial begin
    int br_high, pulses;
    rst = 1'b1; run = 1'b1; req = 1'b0; done = 1'b0; bg = 1'b0; bus_busy = 1'b0;
    model_clear(); m_grants = 0;

    // Reset state
    ticks(2);
    check1("reset_count", gcount, 8'd0);
    rst = 1'b0;
    tick();

    // Basic grant: BG arrives 3 cycles after BR, bus idle
    req = 1'b1;
    tick();
    check1("basic_br", {7'd0, br}, 8'd1);
    ticks(2);
    bg = 1'b1;
    tick();
    check1("basic_no_gnt_yet", {7'd0, gnt}, 8'd0);
    tick();
    check1("basic_gnt", {7'd0, gnt}, 8'd1);
    check1("basic_bgack", {7'd0, bgack}, 8'd1);
    check1("basic_br_low", {7'd0, br}, 8'd0);
    check1("basic_count", gcount, 8'd1);
    bg = 1'b0;
    pulse_done();
    check1("release_gnt", {7'd0, gnt}, 8'd0);
    check1("release_bgack", {7'd0, bgack}, 8'd1);
    tick();
    check1("idle_bgack", {7'd0, bgack}, 8'd0);
    for (int i = 0; i < CPU_SLOT; i++) begin
      tick();
      check1("cooldown_br", {7'd0, br}, 8'd0);
    end
    tick();
    check1("after_cooldown_br", {7'd0, br}, 8'd1);

    // Bus busy: BG present but AS held for 5 cycles
    bg = 1'b1; bus_busy = 1'b1;
    ticks(6);
    check1("busy_gnt", {7'd0, gnt}, 8'd0);
    check1("busy_br", {7'd0, br}, 8'd1);
    bus_busy = 1'b0;
    tick();
    check1("busy_then_gnt", {7'd0, gnt}, 8'd1);

    // Hold limit reached with no DONE
    ticks(MAX_HOLD);
    check1("hold_yield", {7'd0, yld}, 8'd1);
    ticks(10);
    check1("yield_keeps_gnt", {7'd0, gnt}, 8'd1);
    pulse_done();
    check1("yield_release", {7'd0, gnt}, 8'd0);

    // DONE on the hold-limit cycle wins
    wait_grant("grant_for_done_race");
    ticks(MAX_HOLD - 1);
    pulse_done();
    check1("race_no_yield", {7'd0, yld}, 8'd0);
    check1("race_release_bgack", {7'd0, bgack}, 8'd1);

    // Request withdrawn while asking, then immediately re-raised
    bg = 1'b0;
    for (int i = 0; i < 40 && !m_asking; i++) tick();
    req = 1'b0;
    tick();
    check1("withdraw_br", {7'd0, br}, 8'd0);
    req = 1'b1;
    tick();
    check1("rerequest_br", {7'd0, br}, 8'd1);

    // RUN_IN low while the loader owns the bus
    bg = 1'b1;
    wait_grant("grant_for_run_stop");
    run = 1'b0;
    tick();
    check1("runstop_gnt", {7'd0, gnt}, 8'd0);
    check1("runstop_bgack", {7'd0, bgack}, 8'd0);
    run = 1'b1;

    // RESET_IN while yielding
    wait_grant("grant_for_reset");
    ticks(MAX_HOLD);
    rst = 1'b1;
    tick();
    check1("reset_in_yield_count", gcount, 8'd0);
    rst = 1'b0;

    // Grant never comes
    bg = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    br_high = 0; pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (br) br_high++;
      if (tmo) pulses++;
    end
    check1("timeout_br_cycles", 8'(br_high), TO_EN ? 8'(GRANT_TIMEOUT) : 8'd100);
    check1("timeout_pulses", 8'(pulses), TO_EN ? 8'd1 : 8'd0);
    req = 1'b0; tick();
    req = 1'b1; tick();
    check1("retoggle_br", {7'd0, br}, 8'd1);

    // 256 grants wrap the counter
    rst = 1'b1; tick(); rst = 1'b0;
    bg = 1'b1; bus_busy = 1'b0;
    for (int g = 0; g < 256; g++) begin
      wait_grant("wrap_grant");
      pulse_done();
    end
    check1("wrap_count", gcount, 8'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      run      = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 9) == 0) req = ~req;
      done     = ($urandom_range(0, 5) == 0);
      bg       = ($urandom_range(0, 3) != 0);
      bus_busy = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
